circ_ptr_fifo_gen: RTL and testbench

- Parametrised next-generation circular-pointer FIFO: arbitrary (non-power-of-two) depth, selectable first-word-fall-through (FWFT) or registered-read mode, occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags.
- Drop-in storage element for datapaths and for formal harnesses that pair it with a scoreboard.
- Carries its own internal consistency assertions under FORMAL.

---
 rtl/circ_ptr_fifo_gen.sv | 108 ++++++++++
 tb/tb_circ_ptr_fifo_gen.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/circ_ptr_fifo_gen.sv
// circ_ptr_fifo_gen: circular-pointer FIFO of arbitrary depth with FWFT/registered read, thresholds and sticky errors
module circ_ptr_fifo_gen #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 5,
    parameter int FWFT      = 1,
    parameter int AF_THRESH = 4,
    parameter int AE_THRESH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       pop,
    output logic [WIDTH-1:0]           data_out,
    output logic                       data_out_vld,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    if (DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH || AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_param
        $error("circ_ptr_fifo_gen: illegal DEPTH or threshold parameter");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d, underflow_q, underflow_d;
    logic             push_acc, pop_acc;

    assign empty        = count_q == '0;
    assign full         = count_q == CW'(DEPTH);
    assign almost_empty = count_q <= CW'(AE_THRESH);
    assign almost_full  = count_q >= CW'(AF_THRESH);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign push_acc     = push & ~full;
    assign pop_acc      = pop & ~empty;

    // Next-state: pointers wrap by explicit compare so non-power-of-two depths work
    always_comb begin
        wr_ptr_d    = push_acc ? ((wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d    = pop_acc ? ((rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1)) : rd_ptr_q;
        count_d     = (push_acc & ~pop_acc) ? count_q + CW'(1) :
                      (pop_acc & ~push_acc) ? count_q - CW'(1) : count_q;
        overflow_d  = (push & full) | (overflow_q & ~clr_err);
        underflow_d = (pop & empty) | (underflow_q & ~clr_err);
    end

    // Control state; reset discards contents by clearing pointers and count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array is deliberately left unreset
    always_ff @(posedge clk) begin
        if (push_acc) mem_q[wr_ptr_q] <= data_in;
    end

    if (FWFT != 0) begin : g_fwft
        assign data_out     = mem_q[rd_ptr_q];
        assign data_out_vld = ~empty;
    end else begin : g_reg
        logic [WIDTH-1:0] rdata_q;
        logic             rvld_q;
        // Registered read: data lands one cycle after an accepted pop and then holds
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rdata_q <= '0;
                rvld_q  <= 1'b0;
            end else begin
                rvld_q  <= pop_acc;
                if (pop_acc) rdata_q <= mem_q[rd_ptr_q];
            end
        end
        assign data_out     = rdata_q;
        assign data_out_vld = rvld_q;
    end

`ifdef FORMAL
    a_cnt_max: assert property (@(posedge clk) disable iff (!rst) count_q <= CW'(DEPTH));
    a_cnt_ptr: assert property (@(posedge clk) disable iff (!rst)
        ((int'(wr_ptr_q) - int'(rd_ptr_q) + DEPTH) % DEPTH) == ((count_q == CW'(DEPTH)) ? 0 : int'(count_q)));
    a_full_ptr: assert property (@(posedge clk) disable iff (!rst) full |-> (wr_ptr_q == rd_ptr_q));
    a_excl: assert property (@(posedge clk) disable iff (!rst) !(empty && full));
    a_fwft_vld: assert property (@(posedge clk) disable iff (!rst) (FWFT == 0) || (data_out_vld == !empty));
`endif
endmodule

// File: tb/tb_circ_ptr_fifo_gen.sv
// tb_circ_ptr_fifo_gen: directed stimulus with a queue scoreboard for FWFT and registered-read instances
module tb_circ_ptr_fifo_gen;
    logic       clk = 1'b0;
    logic       rst;
    logic       push_f, pop_f, clr_f, push_r, pop_r, clr_r;
    logic [7:0] din_f, din_r, dout_f, dout_r;
    logic       vld_f, empty_f, full_f, ae_f, af_f, ovf_f, udf_f;
    logic       vld_r, empty_r, full_r, ae_r, af_r, ovf_r, udf_r;
    logic [2:0] cnt_f, cnt_r;
    logic [7:0] exp_f[$];
    logic [7:0] exp_r[$];
    int         n_chk = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    circ_ptr_fifo_gen #(.FWFT(1)) u_f (
        .clk(clk), .rst(rst), .push(push_f), .data_in(din_f), .pop(pop_f),
        .data_out(dout_f), .data_out_vld(vld_f), .empty(empty_f), .full(full_f),
        .almost_empty(ae_f), .almost_full(af_f), .count(cnt_f),
        .overflow(ovf_f), .underflow(udf_f), .clr_err(clr_f)
    );

    circ_ptr_fifo_gen #(.FWFT(0)) u_r (
        .clk(clk), .rst(rst), .push(push_r), .data_in(din_r), .pop(pop_r),
        .data_out(dout_r), .data_out_vld(vld_r), .empty(empty_r), .full(full_r),
        .almost_empty(ae_r), .almost_full(af_r), .count(cnt_r),
        .overflow(ovf_r), .underflow(udf_r), .clr_err(clr_r)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic st_f(input string name, input int c, input int e, input int f, input int ae, input int af);
        chk({name, "_count"}, cnt_f, c);
        chk({name, "_empty"}, empty_f, e);
        chk({name, "_full"}, full_f, f);
        chk({name, "_aempty"}, ae_f, ae);
        chk({name, "_afull"}, af_f, af);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic p, input logic [7:0] d, input logic q, input logic c);
        push_f = p;
        din_f  = d;
        pop_f  = q;
        clr_f  = c;
        tick();
        push_f = 1'b0;
        pop_f  = 1'b0;
        clr_f  = 1'b0;
    endtask

    // Monitor: compare whenever a DUT presents a word that is being consumed / is valid
    always @(negedge clk) begin
        if (pop_f && vld_f) begin
            if (exp_f.size() == 0) chk("fwft_unexpected_word", 1, 0);
            else chk("fwft_data", dout_f, exp_f.pop_front());
        end
        if (vld_r) begin
            if (exp_r.size() == 0) chk("reg_unexpected_word", 1, 0);
            else chk("reg_data", dout_r, exp_r.pop_front());
        end
    end

    initial begin
        rst = 1'b0;
        {push_f, pop_f, clr_f, push_r, pop_r, clr_r} = '0;
        din_f = '0;
        din_r = '0;
        #12;
        st_f("reset", 0, 1, 0, 1, 0);
        chk("reset_vld", vld_f, 0);
        chk("reset_ovf", ovf_f, 0);
        chk("reset_udf", udf_f, 0);
        chk("reset_reg_vld", vld_r, 0);
        chk("reset_reg_dout", dout_r, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        for (int i = 1; i <= 5; i++) begin
            op(1'b1, 8'(i * 8'h11), 1'b0, 1'b0);
            st_f("fill", i, 0, int'(i == 5), int'(i <= 1), int'(i >= 4));
        end
        for (int i = 1; i <= 5; i++) begin
            exp_f.push_back(8'(i * 8'h11));
            op(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_count", cnt_f, 5 - i);
        end
        st_f("drained", 0, 1, 0, 1, 0);

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 8; k++) begin
                if (k > 0) exp_f.push_back(8'(8'h10 * (r + 1) + k - 1));
                op(k < 7, 8'(8'h10 * (r + 1) + k), k > 0, 1'b0);
                chk("wrap_count", cnt_f, (k < 7) ? 1 : 0);
            end
        end
        chk("wrap_ovf", ovf_f, 0);
        chk("wrap_udf", udf_f, 0);

        op(1'b1, 8'hA1, 1'b0, 1'b0);
        op(1'b1, 8'hA2, 1'b0, 1'b0);
        exp_f.push_back(8'hA1);
        op(1'b1, 8'hA3, 1'b1, 1'b0);
        chk("simul_count2", cnt_f, 2);
        chk("simul_head", dout_f, 8'hA2);
        op(1'b1, 8'hA4, 1'b0, 1'b0);
        op(1'b1, 8'hA5, 1'b0, 1'b0);
        op(1'b1, 8'hA6, 1'b0, 1'b0);
        st_f("full", 5, 0, 1, 0, 1);
        exp_f.push_back(8'hA2);
        op(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("full_simul_count", cnt_f, 4);
        chk("full_simul_ovf", ovf_f, 1);
        exp_f.push_back(8'hA3);
        exp_f.push_back(8'hA4);
        exp_f.push_back(8'hA5);
        exp_f.push_back(8'hA6);
        for (int i = 0; i < 4; i++) op(1'b0, 8'h00, 1'b1, 1'b0);
        chk("simul_drained", cnt_f, 0);
        op(1'b1, 8'hB1, 1'b1, 1'b0);
        chk("empty_simul_udf", udf_f, 1);
        chk("empty_simul_count", cnt_f, 1);
        exp_f.push_back(8'hB1);
        op(1'b0, 8'h00, 1'b1, 1'b0);

        op(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_ovf", ovf_f, 0);
        chk("clr_udf", udf_f, 0);
        for (int i = 1; i <= 5; i++) op(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        op(1'b1, 8'hCC, 1'b0, 1'b0);
        chk("set_ovf", ovf_f, 1);
        chk("set_ovf_count", cnt_f, 5);
        op(1'b1, 8'hCD, 1'b0, 1'b1);
        chk("clr_vs_set_ovf", ovf_f, 1);
        chk("clr_vs_set_udf", udf_f, 0);
        op(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_again_ovf", ovf_f, 0);
        for (int i = 1; i <= 5; i++) begin
            exp_f.push_back(8'(8'hC0 + i));
            op(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("clr_drained", cnt_f, 0);

        op(1'b1, 8'hD1, 1'b0, 1'b0);
        op(1'b1, 8'hD2, 1'b0, 1'b0);
        op(1'b1, 8'hD3, 1'b0, 1'b0);
        chk("pre_rst_count", cnt_f, 3);
        #2;
        rst = 1'b0;
        #1;
        st_f("async_rst", 0, 1, 0, 1, 0);
        chk("async_rst_vld", vld_f, 0);
        #3;
        rst = 1'b1;
        tick();
        op(1'b1, 8'h77, 1'b0, 1'b0);
        chk("post_rst_head", dout_f, 8'h77);
        exp_f.push_back(8'h77);
        op(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_count", cnt_f, 0);

        push_r = 1'b1;
        din_r  = 8'h3C;
        tick();
        push_r = 1'b0;
        chk("reg_push_count", cnt_r, 1);
        chk("reg_push_vld", vld_r, 0);
        pop_r = 1'b1;
        exp_r.push_back(8'h3C);
        tick();
        pop_r = 1'b0;
        chk("reg_t1_vld", vld_r, 1);
        chk("reg_t1_dout", dout_r, 8'h3C);
        chk("reg_t1_count", cnt_r, 0);
        tick();
        chk("reg_t2_vld", vld_r, 0);
        chk("reg_t2_dout", dout_r, 8'h3C);

        tick();
        chk("queues_drained", exp_f.size() + exp_r.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
